// File: rtl/movegen_sequencer_pkg.sv
// Shared constants and FSM encoding for the move-generation sequencer.
// Register offsets are Avalon word addresses.
package movegen_sequencer_pkg;

  localparam int SQUARE_W    = 6;
  localparam int ADDR_CTRL   = 'h0;
  localparam int ADDR_STATUS = 'h1;
  localparam int ADDR_RANGE  = 'h2;
  localparam int ADDR_COUNT  = 'h3;
  localparam int RESULT_BASE = 'h100;

  localparam logic [SQUARE_W-1:0] SQUARE_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/movegen_result_ram.sv
// Result buffer: one write port fed by the engine, one registered read port for the CSR side.
module movegen_result_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/movegen_sequencer.sv
// CSR-controlled sequencer that walks the engine over a square range and buffers its moves.
//   state      | meaning
//   ST_IDLE    | waiting for START
//   ST_ISSUE   | eng_req high for square cur until eng_ack
//   ST_COLLECT | storing streamed moves, idle timer running
//   ST_DONE    | one cycle; sets done, then back to IDLE
module movegen_sequencer
  import movegen_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int MOVE_WIDTH   = 16,
  parameter int RESULT_DEPTH = 256,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  output logic [DATA_WIDTH-1:0]   slave_readdata,
  input  logic [DATA_WIDTH-1:0]   slave_writedata,
  input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
  output logic                    eng_req,
  output logic [SQUARE_W-1:0]     eng_square,
  input  logic                    eng_ack,
  input  logic                    eng_move_valid,
  input  logic [MOVE_WIDTH-1:0]   eng_move,
  input  logic                    eng_done,
  output logic                    eng_abort,
  output logic                    irq
);

  localparam int IDX_W = $clog2(RESULT_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e              state, state_nxt;
  logic [SQUARE_W-1:0] cur, first_sq, last_sq;
  logic [CNT_W-1:0]    count;
  logic [TMR_W-1:0]    timer;
  logic                done_f, ovf_f, tmo_f, irq_en, abort_q, busy;
  logic                in_ram, wr_ctrl, wr_status, wr_range;
  logic                start_req, abort_busy, collecting, tmo_hit, store_move;
  logic [DATA_WIDTH-1:0] csr_mux, csr_rd;
  logic                rd_ram_q;
  logic [MOVE_WIDTH-1:0] ram_rdata;
  logic                unused_ok;

  assign unused_ok = ^{slave_byteenable, slave_writedata[DATA_WIDTH-1:14], slave_writedata[7:6]};

  assign in_ram    = (slave_address >= ADDR_WIDTH'(RESULT_BASE)) &&
                     (slave_address <  ADDR_WIDTH'(RESULT_BASE + RESULT_DEPTH));
  assign wr_ctrl   = slave_write && (slave_address == ADDR_WIDTH'(ADDR_CTRL));
  assign wr_status = slave_write && (slave_address == ADDR_WIDTH'(ADDR_STATUS));
  assign wr_range  = slave_write && (slave_address == ADDR_WIDTH'(ADDR_RANGE));

  // Abort bit dominates start in the same CTRL write.
  assign start_req  = wr_ctrl && slave_writedata[0] && !slave_writedata[1];
  assign abort_busy = wr_ctrl && slave_writedata[1] && busy;
  assign collecting = (state == ST_COLLECT);
  assign tmo_hit    = collecting && !abort_busy && !eng_move_valid && !eng_done && (timer == '0);
  assign store_move = collecting && eng_move_valid && (count < CNT_W'(RESULT_DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start_req) state_nxt = (first_sq <= last_sq) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: begin
        if (abort_busy)   state_nxt = ST_IDLE;
        else if (eng_ack) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (abort_busy)    state_nxt = ST_IDLE;
        else if (eng_done) state_nxt = (cur == last_sq) ? ST_DONE : ST_ISSUE;
        else if (tmo_hit)  state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_req    = 1'b0;
    eng_square = '0;
    busy       = 1'b0;
    unique case (state)
      ST_ISSUE: begin
        eng_req    = 1'b1;
        eng_square = cur;
        busy       = 1'b1;
      end
      ST_COLLECT: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur      <= '0;
      first_sq <= '0;
      last_sq  <= SQUARE_MAX;
      count    <= '0;
      timer    <= '0;
      done_f   <= 1'b0;
      ovf_f    <= 1'b0;
      tmo_f    <= 1'b0;
      irq_en   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= abort_busy || tmo_hit;
      if (wr_ctrl) irq_en <= slave_writedata[2];
      if (wr_range && !busy) begin
        first_sq <= slave_writedata[5:0];
        last_sq  <= slave_writedata[13:8];
      end
      if (wr_status) begin
        if (slave_writedata[1]) done_f <= 1'b0;
        if (slave_writedata[2]) ovf_f  <= 1'b0;
        if (slave_writedata[3]) tmo_f  <= 1'b0;
      end
      if (state == ST_IDLE && start_req) begin
        count  <= '0;
        done_f <= 1'b0;
        ovf_f  <= 1'b0;
        tmo_f  <= 1'b0;
        cur    <= first_sq;
      end
      if (state == ST_ISSUE && eng_ack) timer <= TMR_W'(TIMEOUT);
      if (collecting) begin
        if (eng_move_valid) begin
          timer <= TMR_W'(TIMEOUT);
          if (store_move) count <= count + CNT_W'(1);
          else            ovf_f <= 1'b1;
        end else if (timer != '0) begin
          timer <= timer - TMR_W'(1);
        end
        if (eng_done && !abort_busy && cur != last_sq) cur <= cur + SQUARE_W'(1);
        if (tmo_hit) tmo_f <= 1'b1;
      end
      if (state == ST_DONE) done_f <= 1'b1;
    end
  end

  always_comb begin
    csr_mux = '0;
    if (slave_address == ADDR_WIDTH'(ADDR_CTRL)) begin
      csr_mux[2] = irq_en;
    end else if (slave_address == ADDR_WIDTH'(ADDR_STATUS)) begin
      csr_mux[3:0] = {tmo_f, ovf_f, done_f, busy};
    end else if (slave_address == ADDR_WIDTH'(ADDR_RANGE)) begin
      csr_mux[13:8] = last_sq;
      csr_mux[5:0]  = first_sq;
    end else if (slave_address == ADDR_WIDTH'(ADDR_COUNT)) begin
      csr_mux = DATA_WIDTH'(count);
    end
  end

  // Buffer reads come from the RAM's own output register; the select is registered alongside.
  always_ff @(posedge clk) begin
    if (!reset) begin
      csr_rd   <= '0;
      rd_ram_q <= 1'b0;
    end else if (slave_read) begin
      csr_rd   <= csr_mux;
      rd_ram_q <= in_ram;
    end
  end

  movegen_result_ram #(
    .DEPTH (RESULT_DEPTH),
    .WIDTH (MOVE_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (store_move && reset),
    .waddr (count[IDX_W-1:0]),
    .wdata (eng_move),
    .re    (slave_read && in_ram),
    .raddr (slave_address[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  assign slave_readdata = rd_ram_q ? DATA_WIDTH'(ram_rdata) : csr_rd;
  assign eng_abort      = abort_q;
  assign irq            = done_f & irq_en;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed + randomized bench for movegen_sequencer with a queue-based model of the result buffer.
module tb_movegen_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 15;
  localparam int MW    = 16;
  localparam int DEPTH = 256;
  localparam int TMO   = 1023;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] slave_address = '0;
  logic          slave_read = 1'b0;
  logic          slave_write = 1'b0;
  logic [DW-1:0] slave_readdata;
  logic [DW-1:0] slave_writedata = '0;
  logic          eng_req;
  logic [5:0]    eng_square;
  logic          eng_ack = 1'b0;
  logic          eng_move_valid = 1'b0;
  logic [MW-1:0] eng_move = '0;
  logic          eng_done = 1'b0;
  logic          eng_abort;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] model_q[$];

  movegen_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MOVE_WIDTH(MW), .RESULT_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
    .slave_byteenable(4'hF),
    .eng_req(eng_req), .eng_square(eng_square), .eng_ack(eng_ack),
    .eng_move_valid(eng_move_valid), .eng_move(eng_move), .eng_done(eng_done),
    .eng_abort(eng_abort), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    slave_address = AW'(addr);
    slave_writedata = data;
    slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [31:0] data);
    @(negedge clk);
    slave_address = AW'(addr);
    slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    data = slave_readdata;
  endtask

  task automatic check_reg(input string tag, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic wait_req();
    int w;
    w = 0;
    while (!eng_req && w < 50) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int w;
    w = 0;
    do begin
      bus_read(1, d);
      w++;
    end while (d[0] && w < 100);
    check("idle_reached", {31'b0, d[0]}, 0);
  endtask

  // Acts as the engine for one square; every move sent is also pushed into the model queue.
  task automatic serve(input int sq, input int nmoves, input bit coincide, input bit finish_sq);
    logic [MW-1:0] m;
    wait_req();
    check("eng_req_seen", {31'b0, eng_req}, 1);
    check("eng_square", {26'b0, eng_square}, sq);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("eng_req_held", {31'b0, eng_req}, 1);
    check("eng_square_held", {26'b0, eng_square}, sq);
    eng_ack = 1'b1;
    @(negedge clk);
    eng_ack = 1'b0;
    for (int i = 0; i < nmoves; i++) begin
      m = MW'($urandom);
      eng_move_valid = 1'b1;
      eng_move = m;
      eng_done = finish_sq && coincide && (i == nmoves - 1);
      model_q.push_back(m);
      @(negedge clk);
    end
    eng_move_valid = 1'b0;
    if (finish_sq && !(coincide && nmoves > 0)) begin
      eng_done = 1'b1;
      @(negedge clk);
    end
    eng_done = 1'b0;
  endtask

  task automatic run_seq(input int first, input int last, input bit irq_on,
                         input int n_first, input int n_rest);
    int n;
    int exp_cnt;
    model_q.delete();
    bus_write(2, (last << 8) | first);
    bus_write(0, irq_on ? 5 : 1);
    for (int sq = first; sq <= last; sq++) begin
      n = (sq == first) ? n_first : n_rest;
      if (n < 0) n = $urandom_range(0, 5);
      serve(sq, n, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_idle();
    exp_cnt = (model_q.size() > DEPTH) ? DEPTH : model_q.size();
    check_reg("status_done", 1, (model_q.size() > DEPTH) ? 32'h6 : 32'h2);
    check_reg("move_count", 3, exp_cnt);
    for (int i = 0; i < exp_cnt; i++) check_reg($sformatf("buf_%0d", i), 'h100 + i, 32'(model_q[i]));
    check("irq_level", {31'b0, irq}, {31'b0, irq_on});
  endtask

  initial begin
    logic seen;
    int n;
    int f;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_eng_req", {31'b0, eng_req}, 0);
    check("rst_eng_square", {26'b0, eng_square}, 0);
    check("rst_eng_abort", {31'b0, eng_abort}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    check("rst_readdata", slave_readdata, 0);
    reset = 1'b1;
    check_reg("rst_range", 2, 32'h3F00);
    check_reg("rst_status", 1, 0);
    check_reg("rst_count", 3, 0);
    check_reg("rst_ctrl", 0, 0);
    check_reg("unmapped_read", 'h10, 0);

    // Two squares, 3 then 2 moves, irq enabled
    run_seq(0, 1, 1'b1, 3, 2);

    // Start together with abort must not start anything
    bus_write(0, 7);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= eng_req; end
    check("start_abort_no_req", {31'b0, seen}, 0);
    check_reg("start_abort_status", 1, 32'h2);
    check_reg("start_abort_count", 3, 5);
    bus_write(0, 0);
    check("irq_disabled", {31'b0, irq}, 0);
    bus_write(1, 32'h2);
    check_reg("status_w1c", 1, 0);

    // Random ranges, first one ending on square 63
    for (int t = 0; t < 3; t++) begin
      f = (t == 0) ? 62 : $urandom_range(0, 60);
      run_seq(f, f + ((t == 0) ? 1 : $urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, -1);
    end

    // Empty range: first > last
    bus_write(2, 32'h0305);
    bus_write(0, 1);
    seen = eng_req;
    repeat (6) begin @(negedge clk); seen |= eng_req; end
    check("empty_no_req", {31'b0, seen}, 0);
    check_reg("empty_status", 1, 32'h2);
    check_reg("empty_count", 3, 0);

    // Overflow: 260 moves on one square
    run_seq(7, 7, 1'b0, 260, 0);

    // Timeout in COLLECT
    bus_write(2, 32'h0000);
    bus_write(0, 1);
    wait_req();
    check("tmo_req", {31'b0, eng_req}, 1);
    eng_ack = 1'b1;
    @(negedge clk);
    eng_ack = 1'b0;
    n = 0;
    while (!eng_abort && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_abort_cycle", n, TMO + 1);
    @(negedge clk);
    check("tmo_abort_width", {31'b0, eng_abort}, 0);
    check_reg("tmo_status", 1, 32'hA);
    check_reg("tmo_count", 3, 0);

    // Abort mid-COLLECT keeps count and buffer, no done
    model_q.delete();
    bus_write(2, 32'h0B0A);
    bus_write(0, 1);
    serve(10, 3, 1'b0, 1'b0);
    bus_write(0, 2);
    check("abort_pulse", {31'b0, eng_abort}, 1);
    check("abort_req_low", {31'b0, eng_req}, 0);
    @(negedge clk);
    check("abort_pulse_width", {31'b0, eng_abort}, 0);
    check_reg("abort_status", 1, 0);
    check_reg("abort_count", 3, 3);
    for (int i = 0; i < 3; i++) check_reg($sformatf("abort_buf_%0d", i), 'h100 + i, 32'(model_q[i]));

    // Range locked while busy, then reset mid-ISSUE
    bus_write(0, 1);
    wait_req();
    check("issue_req", {31'b0, eng_req}, 1);
    bus_write(2, 32'h2020);
    check_reg("range_locked", 2, 32'h0B0A);
    check("issue_req_still", {31'b0, eng_req}, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_eng_req", {31'b0, eng_req}, 0);
    check("rst2_eng_square", {26'b0, eng_square}, 0);
    check("rst2_eng_abort", {31'b0, eng_abort}, 0);
    @(negedge clk);
    reset = 1'b1;
    check_reg("rst2_range", 2, 32'h3F00);
    check_reg("rst2_count", 3, 0);
    check_reg("rst2_status", 1, 0);
    check("rst2_irq", {31'b0, irq}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
